// File: rtl/arb_pkg.sv
// Shared constants for the memory-arbiter client protocol.
package arb_pkg;

  localparam int unsigned ADDR_W      = 17;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_CLIENTS = 3;

  localparam logic [3:0] OP_FULL_WRITE = 4'hF;

  localparam int unsigned CID_FETCH  = 0;
  localparam int unsigned CID_LINE   = 1;
  localparam int unsigned CID_CIRCLE = 2;

  // Any op other than a full write returns one word of read data.
  function automatic logic is_read(input logic [3:0] op);
    return op != OP_FULL_WRITE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, storage and pointers cleared on reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers (wrap modulo depth) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_) !(push && full))
    else $error("sync_fifo: push while full");

endmodule

// File: rtl/arb_client_port.sv
// Client endpoint of the memory-arbiter protocol: request queue toward the
// arbiter, credit-protected capture of broadcast read data, in-order response.
// Optional watchdog enabled by defining ARB_PORT_TIMEOUT_EN.
module arb_client_port #(
  parameter int unsigned CLIENT_ID      = arb_pkg::CID_FETCH,
  parameter int unsigned NUM_CLIENTS    = arb_pkg::NUM_CLIENTS,
  parameter int unsigned ADDR_W         = arb_pkg::ADDR_W,
  parameter int unsigned DATA_W         = arb_pkg::DATA_W,
  parameter int unsigned REQ_DEPTH      = 4,
  parameter int unsigned RSP_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   eng_req_valid,
  output logic                   eng_req_ready,
  input  logic [ADDR_W-1:0]      eng_req_addr,
  input  logic [DATA_W-1:0]      eng_req_wrdata,
  input  logic [3:0]             eng_req_op,
  output logic                   arb_rts_out,
  input  logic                   arb_rtr_in,
  output logic [ADDR_W-1:0]      arb_addr,
  output logic [DATA_W-1:0]      arb_wrdata,
  output logic [3:0]             arb_op,
  input  logic [DATA_W-1:0]      bcast_data,
  input  logic [NUM_CLIENTS-1:0] bcast_xfc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   busy,
  output logic                   err_spurious,
  output logic                   timeout_err
);

  import arb_pkg::*;

  localparam int unsigned REQ_W = ADDR_W + DATA_W + 4;
  localparam int unsigned CW    = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned QW    = $clog2(REQ_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_CREDITS = CW'(RSP_DEPTH);

  if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0 ||
      RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 ||
      CLIENT_ID >= NUM_CLIENTS || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("arb_client_port: illegal parameter set");
  end

  logic             req_full, req_empty;
  logic [QW-1:0]    req_count;
  logic [REQ_W-1:0] req_head;
  logic             rsp_full, rsp_empty;
  logic [CW-1:0]    rsp_count;

  logic [CW-1:0]    credits_q, credits_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic             err_spurious_q, err_spurious_d;

  logic accept, xfc, strobe, ret, rsp_pop, credit_inc, out_inc;

  // ready looks at the registered full flag, so accept+pop on a full queue is never combinationally looped
  assign eng_req_ready = !req_full && (eng_req_op == OP_FULL_WRITE || credits_q < MAX_CREDITS);
  assign accept        = eng_req_valid && eng_req_ready;
  assign arb_rts_out   = !req_empty;
  assign xfc           = arb_rts_out && arb_rtr_in;
  assign {arb_addr, arb_wrdata, arb_op} = req_head;

  assign strobe     = |(bcast_xfc & (NUM_CLIENTS'(1) << CLIENT_ID));
  assign ret        = strobe && (outstanding_q != '0);
  assign rsp_valid  = !rsp_empty;
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign credit_inc = accept && is_read(eng_req_op);
  assign out_inc    = xfc && is_read(arb_op);

  assign busy         = (req_count != '0) || (outstanding_q != '0) || rsp_valid;
  assign err_spurious = err_spurious_q;

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push    (accept),
    .wr_data ({eng_req_addr, eng_req_wrdata, eng_req_op}),
    .pop     (xfc),
    .rd_data (req_head),
    .full    (req_full),
    .empty   (req_empty),
    .count   (req_count)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push    (ret),
    .wr_data (bcast_data),
    .pop     (rsp_pop),
    .rd_data (rsp_data),
    .full    (rsp_full),
    .empty   (rsp_empty),
    .count   (rsp_count)
  );

  // Credit, outstanding-read and spurious-return bookkeeping.
  always_comb begin
    credits_d      = credits_q;
    outstanding_d  = outstanding_q;
    err_spurious_d = err_spurious_q;
    if (credit_inc && !rsp_pop) begin
      credits_d = credits_q + 1'b1;
    end else if (!credit_inc && rsp_pop) begin
      credits_d = credits_q - 1'b1;
    end
    if (out_inc && !ret) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!out_inc && ret) begin
      outstanding_d = outstanding_q - 1'b1;
    end
    if (strobe && outstanding_q == '0) begin
      err_spurious_d = 1'b1;
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      credits_q      <= '0;
      outstanding_q  <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      credits_q      <= credits_d;
      outstanding_q  <= outstanding_d;
      err_spurious_q <= err_spurious_d;
    end
  end

`ifdef ARB_PORT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] wd_q, wd_d;
  logic          timeout_err_q, timeout_err_d;

  // Watchdog counts stalled cycles while reads are outstanding; saturates at the limit.
  always_comb begin
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
    if (ret || outstanding_q == '0) begin
      wd_d = '0;
    end else if (wd_q != TLIM) begin
      wd_d = wd_q + 1'b1;
    end
    if (wd_d == TLIM) begin
      timeout_err_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  a_rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst_) !(ret && rsp_full))
    else $error("arb_client_port: response overflow");

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_)
      ((CW+1)'(outstanding_q) + (CW+1)'(rsp_count)) <= (CW+1)'(credits_q))
    else $error("arb_client_port: credits below reads in flight");

endmodule

// File: tb/tb_arb_client_port.sv
// Directed bench for arb_client_port: cycle table plus multi-cycle sequences.
module tb_arb_client_port;

  import arb_pkg::*;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_;
  logic          eng_req_valid;
  logic          eng_req_ready;
  logic [AW-1:0] eng_req_addr;
  logic [DW-1:0] eng_req_wrdata;
  logic [3:0]    eng_req_op;
  logic          arb_rts_out;
  logic          arb_rtr_in;
  logic [AW-1:0] arb_addr;
  logic [DW-1:0] arb_wrdata;
  logic [3:0]    arb_op;
  logic [DW-1:0] bcast_data;
  logic [2:0]    bcast_xfc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          err_spurious;
  logic          timeout_err;

  always #5 clk = ~clk;

  arb_client_port #(
    .CLIENT_ID      (CID_FETCH),
    .NUM_CLIENTS    (3),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .REQ_DEPTH      (4),
    .RSP_DEPTH      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst_           (rst_),
    .eng_req_valid  (eng_req_valid),
    .eng_req_ready  (eng_req_ready),
    .eng_req_addr   (eng_req_addr),
    .eng_req_wrdata (eng_req_wrdata),
    .eng_req_op     (eng_req_op),
    .arb_rts_out    (arb_rts_out),
    .arb_rtr_in     (arb_rtr_in),
    .arb_addr       (arb_addr),
    .arb_wrdata     (arb_wrdata),
    .arb_op         (arb_op),
    .bcast_data     (bcast_data),
    .bcast_xfc      (bcast_xfc),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .err_spurious   (err_spurious),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    logic          vld;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [3:0]    op;
    logic          rtr;
    logic [2:0]    bx;
    logic [DW-1:0] bd;
    logic          rr;
    logic          e_ready;
    logic          e_rts;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [3:0]    e_op;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic tmo_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic vld, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                               input logic [3:0] op, input logic rtr, input logic [2:0] bx,
                               input logic [DW-1:0] bd, input logic rr, input logic e_ready,
                               input logic e_rts, input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd,
                               input logic [3:0] e_op, input logic e_rv, input logic [DW-1:0] e_rd,
                               input logic e_busy);
    vec_t v;
    v.vld = vld; v.addr = addr; v.wd = wd; v.op = op; v.rtr = rtr; v.bx = bx; v.bd = bd; v.rr = rr;
    v.e_ready = e_ready; v.e_rts = e_rts; v.e_addr = e_addr; v.e_wd = e_wd; v.e_op = e_op;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},   eng_req_ready, 1'b1);
    chk({tag, "_rts"},     arb_rts_out,   1'b0);
    chk({tag, "_addr"},    arb_addr,      '0);
    chk({tag, "_wrdata"},  arb_wrdata,    '0);
    chk({tag, "_op"},      arb_op,        '0);
    chk({tag, "_rsp_vld"}, rsp_valid,     1'b0);
    chk({tag, "_rsp_dat"}, rsp_data,      '0);
    chk({tag, "_busy"},    busy,          1'b0);
    chk({tag, "_spur"},    err_spurious,  1'b0);
    chk({tag, "_tmo"},     timeout_err,   1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl[$];

`ifdef ARB_PORT_TIMEOUT_EN
    tmo_exp = 1'b1;
`else
    tmo_exp = 1'b0;
`endif

    // Single read with a 3-cycle return, then a full write with another client's strobe.
    tbl.push_back(mkv(1, 17'h00010, 32'h0, 4'h0, 1, 3'b000, 32'h0,        0, 1, 0, 17'h0,     32'h0,        4'h0, 0, 32'h0,        0));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b000, 32'h0,        0, 1, 1, 17'h00010, 32'h0,        4'h0, 0, 32'h0,        1));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b000, 32'h0,        0, 1, 0, 17'h0,     32'h0,        4'h0, 0, 32'h0,        1));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b000, 32'h0,        0, 1, 0, 17'h0,     32'h0,        4'h0, 0, 32'h0,        1));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b001, 32'hDEADBEEF, 0, 1, 0, 17'h0,     32'h0,        4'h0, 0, 32'h0,        1));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b000, 32'h0,        0, 1, 0, 17'h0,     32'h0,        4'h0, 1, 32'hDEADBEEF, 1));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b000, 32'h0,        1, 1, 0, 17'h0,     32'h0,        4'h0, 1, 32'hDEADBEEF, 1));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b000, 32'h0,        0, 1, 0, 17'h0,     32'h0,        4'h0, 0, 32'h0,        0));
    tbl.push_back(mkv(1, 17'h00020, 32'h12345678, 4'hF, 1, 3'b000, 32'h0, 0, 1, 0, 17'h0,     32'h0,        4'h0, 0, 32'h0,        0));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b010, 32'hCAFEF00D, 0, 1, 1, 17'h00020, 32'h12345678, 4'hF, 0, 32'h0,        1));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b000, 32'h0,        0, 1, 0, 17'h0,     32'h0,        4'h0, 0, 32'h0,        0));
    tbl.push_back(mkv(0, 17'h0,     32'h0, 4'h0, 1, 3'b000, 32'h0,        0, 1, 0, 17'h0,     32'h0,        4'h0, 0, 32'h0,        0));

    rst_ = 1'b0;
    eng_req_valid = 0; eng_req_addr = '0; eng_req_wrdata = '0; eng_req_op = '0;
    arb_rtr_in = 0; bcast_data = '0; bcast_xfc = '0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_ = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      eng_req_valid = tbl[i].vld; eng_req_addr = tbl[i].addr; eng_req_wrdata = tbl[i].wd;
      eng_req_op = tbl[i].op; arb_rtr_in = tbl[i].rtr; bcast_xfc = tbl[i].bx;
      bcast_data = tbl[i].bd; rsp_ready = tbl[i].rr;
      #2;
      chk($sformatf("v%0d_ready", i), eng_req_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_rts", i), arb_rts_out, tbl[i].e_rts);
      if (tbl[i].e_rts) begin
        chk($sformatf("v%0d_addr", i), arb_addr, tbl[i].e_addr);
        chk($sformatf("v%0d_wrdata", i), arb_wrdata, tbl[i].e_wd);
        chk($sformatf("v%0d_op", i), arb_op, tbl[i].e_op);
      end
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("v%0d_rsp_data", i), rsp_data, tbl[i].e_rd);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_spur", i), err_spurious, 1'b0);
    end

    // Credits: four reads fill the credit pool; a fifth read stalls, a write does not.
    @(negedge clk);
    bcast_xfc = '0; rsp_ready = 0; arb_rtr_in = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      eng_req_valid = 1; eng_req_op = 4'h0; eng_req_addr = AW'(17'h100 + i);
      #2 chk($sformatf("cred_read%0d_ready", i), eng_req_ready, 1'b1);
    end
    @(negedge clk);
    eng_req_valid = 1; eng_req_op = 4'h0; eng_req_addr = 17'h104;
    #2 chk("cred_read4_blocked", eng_req_ready, 1'b0);
    eng_req_op = 4'hF; eng_req_addr = 17'h1F0; eng_req_wrdata = 32'hF00DF00D;
    #1 chk("cred_write_ok", eng_req_ready, 1'b1);
    @(negedge clk);
    eng_req_valid = 0; eng_req_op = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bcast_xfc = 3'b001; bcast_data = DW'(32'hA0 + i);
    end
    @(negedge clk);
    bcast_xfc = '0;
    #2;
    chk("cred_rsp_valid", rsp_valid, 1'b1);
    chk("cred_rsp_data0", rsp_data, 32'hA0);
    eng_req_valid = 1; eng_req_op = 4'h0; eng_req_addr = 17'h104;
    #1 chk("cred_still_blocked", eng_req_ready, 1'b0);
    eng_req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0; eng_req_valid = 1; eng_req_op = 4'h0; eng_req_addr = 17'h104;
    #2 chk("cred_reenabled", eng_req_ready, 1'b1);
    @(negedge clk);
    eng_req_valid = 0; rsp_ready = 1;
    for (int i = 1; i < 4; i++) begin
      #2;
      chk($sformatf("cred_rsp_valid%0d", i), rsp_valid, 1'b1);
      chk($sformatf("cred_rsp_data%0d", i), rsp_data, DW'(32'hA0 + i));
      @(negedge clk);
    end
    rsp_ready = 0;
    #2 chk("cred_rsp_drained", rsp_valid, 1'b0);
    bcast_xfc = 3'b001; bcast_data = 32'hA4;
    @(negedge clk);
    bcast_xfc = '0;
    #2 chk("cred_rsp_data4", rsp_data, 32'hA4);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    #2;
    chk("cred_idle_rsp", rsp_valid, 1'b0);
    chk("cred_idle_busy", busy, 1'b0);

    // Backpressure: four queued writes held by rtr=0, then drained in order.
    arb_rtr_in = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      eng_req_valid = 1; eng_req_op = 4'hF; eng_req_addr = AW'(17'h200 + i);
      eng_req_wrdata = DW'(32'hB0000000 + i);
      #2 chk($sformatf("bp_fill%0d_ready", i), eng_req_ready, 1'b1);
    end
    @(negedge clk);
    eng_req_addr = 17'h2FF;
    for (int k = 0; k < 10; k++) begin
      #2;
      chk($sformatf("bp_hold%0d_ready", k), eng_req_ready, 1'b0);
      chk($sformatf("bp_hold%0d_rts", k), arb_rts_out, 1'b1);
      chk($sformatf("bp_hold%0d_addr", k), arb_addr, 17'h200);
      chk($sformatf("bp_hold%0d_wrdata", k), arb_wrdata, 32'hB0000000);
      @(negedge clk);
    end
    eng_req_valid = 0; arb_rtr_in = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("bp_drain%0d_rts", i), arb_rts_out, 1'b1);
      chk($sformatf("bp_drain%0d_addr", i), arb_addr, AW'(17'h200 + i));
      chk($sformatf("bp_drain%0d_wrdata", i), arb_wrdata, DW'(32'hB0000000 + i));
      @(negedge clk);
    end
    #2;
    chk("bp_empty_rts", arb_rts_out, 1'b0);
    chk("bp_empty_busy", busy, 1'b0);

    // Spurious return with nothing outstanding.
    @(negedge clk);
    bcast_xfc = 3'b001; bcast_data = 32'h55;
    #2 chk("spur_before", err_spurious, 1'b0);
    @(negedge clk);
    bcast_xfc = '0;
    #2;
    chk("spur_set", err_spurious, 1'b1);
    chk("spur_no_rsp", rsp_valid, 1'b0);
    chk("spur_busy", busy, 1'b0);

    // Mid-burst reset with a response pending and reads queued.
    @(negedge clk);
    arb_rtr_in = 1; eng_req_valid = 1; eng_req_op = 4'h0; eng_req_addr = 17'h300;
    @(negedge clk);
    eng_req_valid = 0;
    @(negedge clk);
    bcast_xfc = 3'b001; bcast_data = 32'h77;
    @(negedge clk);
    bcast_xfc = '0; arb_rtr_in = 0;
    #2;
    chk("mid_rsp_valid", rsp_valid, 1'b1);
    chk("mid_rsp_data", rsp_data, 32'h77);
    eng_req_valid = 1; eng_req_op = 4'h0; eng_req_addr = 17'h301;
    @(negedge clk);
    eng_req_addr = 17'h302;
    @(negedge clk);
    eng_req_valid = 0;
    #2;
    chk("mid_rts", arb_rts_out, 1'b1);
    chk("mid_busy", busy, 1'b1);
    #1 rst_ = 1'b0;
    #1 chk_reset_outputs("midrst_asserted");
    @(negedge clk);
    rst_ = 1'b1;
    #2 chk_reset_outputs("midrst_released");
    @(negedge clk);
    bcast_xfc = 3'b001; bcast_data = 32'h99;
    @(negedge clk);
    bcast_xfc = '0;
    #2;
    chk("post_rst_spur", err_spurious, 1'b1);
    chk("post_rst_no_rsp", rsp_valid, 1'b0);

    // Watchdog: one read never returns.
    rst_ = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    arb_rtr_in = 1;
    @(negedge clk);
    eng_req_valid = 1; eng_req_op = 4'h0; eng_req_addr = 17'h400;
    @(negedge clk);
    eng_req_valid = 0;
    @(negedge clk);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      #2 chk($sformatf("tmo_wait%0d", k), timeout_err, 1'b0);
    end
    @(negedge clk);
    #2 chk("tmo_reached", timeout_err, tmo_exp);
    bcast_xfc = 3'b001; bcast_data = 32'h4242;
    @(negedge clk);
    bcast_xfc = '0;
    #2;
    chk("tmo_sticky", timeout_err, tmo_exp);
    chk("tmo_late_rsp", rsp_data, 32'h4242);
    chk("tmo_late_no_spur", err_spurious, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
